peak_report_receiver: RTL
=========================

// Module: peak_report_receiver
// PURPOSE
// - Consumer end of the 512-bit single-beat peak-report stream produced by the matched-filter range detector.
// - Validates each report (magic, tag, duplicated fields, framing) and tracks chirp counter_id continuity.
// - Latches the last good peak fields for register readout.
// - Re-serialises each good report as a 4-word 64-bit AXI-Stream packet for the Ethernet/DMA path.
// PARAMETERS
// - S_AXI_DATA_WIDTH  512  input beat width; only 512 is supported (elaboration error otherwise)
// - M_AXI_DATA_WIDTH  64   output word width; only 64 is supported
// - CHECK_SEQUENCE    1    1: count counter_id gaps; 0: gap_count is held at 0
// - DROP_ON_ERROR     1    1: invalid reports produce no output; 0: forward them with word3[63]=1
// PORTS
// - aclk                 in   1    single clock
// - aresetn              in   1    asynchronous, active-low reset
// - s_axis_tdata         in   512  report beat (layout below)
// - s_axis_tvalid        in   1    input valid
// - s_axis_tlast         in   1    must be 1 on every beat
// - s_axis_tready        out  1    input ready
// - m_axis_tdata         out  64   serialised report word
// - m_axis_tvalid        out  1    output valid
// - m_axis_tlast         out  1    high on word 3
// - m_axis_tready        in   1    output ready
// - clear_counters       in   1    synchronous clear of the three counters
// - pkt_count            out  32   good reports accepted (saturating)
// - err_count            out  32   invalid reports (saturating)
// - gap_count            out  32   counter_id discontinuities (saturating)
// - last_counter_id      out  64   latched from last good report
// - last_peak_index      out  32   latched from last good report
// - last_peak_val        out  64   latched from last good report
// - last_num_peaks       out  32   latched from last good report
// - report_valid         out  1    one-cycle pulse when the last_* fields update
// BEHAVIOUR
// - Input layout (bits): [31:0]=32'h504B504B; [47:32]=16'hBEEF; [55:48]=thr; [63:56]=thr dup;
//   [127:64]=counter_id; [159:128]=awg_ctrl; [191:160]=freq_off; [223:192]=tw_coeff; [255:224]=count_max;
//   [287:256]/[319:288]=peak_index x2; [383:320]/[447:384]=peak_val x2; [479:448]/[511:480]=num_peaks x2.
// - Reset values: all outputs 0, except s_axis_tready=1 once in IDLE after reset release.
//   Reset mid-packet abandons the packet; no partial words appear after release.
// - FSM IDLE -> CHECK -> EMIT(w0..w3) -> IDLE. DROP_ON_ERROR=1 with an invalid report: CHECK -> IDLE.
// - IDLE: s_axis_tready=1 (registered, IDLE only). The beat is captured on tvalid&tready at cycle T.
// - CHECK (T+1): valid = magic ok & tag ok & all dups equal & tlast==1. Missing tlast is a framing error.
// - Counter update in CHECK:
//   - Good report: pkt_count+1; last_* fields load; report_valid=1 for exactly this cycle.
//   - Bad report: err_count+1; last_* fields unchanged.
// - Sequence check (CHECK_SEQUENCE=1): on a good report that is not the first since reset or clear,
//   counter_id != last_counter_id+1 (64-bit wrap, FFFF..F -> 0 is continuous) increments gap_count.
//   The report is still forwarded.
// - EMIT: m_axis_tvalid first rises at T+2; words advance on tvalid&tready; tdata/tlast hold while tready=0.
//   - w0 = counter_id
//   - w1 = {peak_index, num_peaks}
//   - w2 = peak_val
//   - w3 = {err_flag, 7'b0, thr, 16'b0, count_max}
// - s_axis_tready returns high the cycle after the w3 handshake. Minimum spacing is 6 cycles per report.
// - Counters saturate at 32'hFFFFFFFF. clear_counters zeroes all three and the first-report flag.
//   clear_counters wins over a same-cycle increment. last_* fields are not cleared.
// STRUCTURE
// - Shared package peak_report_pkg: field bit offsets, PK_MAGIC=32'h504B504B, PK_TAG=16'hBEEF, FSM state enum.
//   The detector is to be migrated onto the same offsets.
// - Sub-module sat_counter32 (inc, clr, q; clr priority), instantiated three times.
// - Field validation stays inline.
// TESTING
// 1. Good report (counter_id=5, peak_index=0x123, peak_val=0xABCD, num_peaks=2), tready=1
//    -> w0=5, w1=0x00000123_00000002, w2=0xABCD, tlast on w3; pkt_count=1.
// 2. Byte 0 of magic corrupted -> no m_axis output; err_count=1; last_* unchanged; tready high again at T+2.
// 3. counter_ids 7, 8, 10 -> gap_count=1. Then FFFF_FFFF_FFFF_FFFF followed by 0 -> gap_count still 1.
// 4. m_axis_tready toggled 1010... -> 4 words in order; tdata stable while stalled; s_axis_tready low
//    until after the w3 handshake.
// 5. aresetn asserted after w1 -> all outputs 0 immediately. After release, the next report emits a clean w0..w3.
// 6. clear_counters in the same cycle as a good CHECK -> pkt_count=0. tlast=0 beat -> err_count+1.

Source files
------------

// File: rtl/peak_report_pkg.sv
// Shared definitions for the peak-report stream: field offsets, framing constants and receiver FSM states.
// The range detector is intended to build its beats from the same offsets.
package peak_report_pkg;

  localparam logic [31:0] PK_MAGIC = 32'h504B504B;
  localparam logic [15:0] PK_TAG   = 16'hBEEF;

  localparam int PK_MAGIC_LSB    = 0;
  localparam int PK_TAG_LSB      = 32;
  localparam int PK_THR_LSB      = 48;
  localparam int PK_THR_DUP_LSB  = 56;
  localparam int PK_CID_LSB      = 64;
  localparam int PK_AWG_LSB      = 128;
  localparam int PK_FREQ_LSB     = 160;
  localparam int PK_TW_LSB       = 192;
  localparam int PK_CMAX_LSB     = 224;
  localparam int PK_PIDX_LSB     = 256;
  localparam int PK_PIDX_DUP_LSB = 288;
  localparam int PK_PVAL_LSB     = 320;
  localparam int PK_PVAL_DUP_LSB = 384;
  localparam int PK_NPK_LSB      = 448;
  localparam int PK_NPK_DUP_LSB  = 480;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_W0    = 3'd2,
    ST_W1    = 3'd3,
    ST_W2    = 3'd4,
    ST_W3    = 3'd5
  } pk_state_e;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones; a synchronous clear overrides a same-cycle increment.
module sat_counter32 (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] q
);

  logic [31:0] q_r;

  // count register: clear first, then saturating increment
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q_r <= 32'd0;
    end else if (clr) begin
      q_r <= 32'd0;
    end else if (inc && (q_r != 32'hFFFF_FFFF)) begin
      q_r <= q_r + 32'd1;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/peak_report_receiver.sv
// Receives 512-bit peak reports, validates them, tracks counter_id continuity, latches the last good
// report and re-serialises each report as a four-word 64-bit stream packet.
module peak_report_receiver
  import peak_report_pkg::*;
#(
  parameter int S_AXI_DATA_WIDTH = 512,
  parameter int M_AXI_DATA_WIDTH = 64,
  parameter bit CHECK_SEQUENCE   = 1'b1,
  parameter bit DROP_ON_ERROR    = 1'b1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [S_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  input  logic                        clear_counters,
  output logic [31:0]                 pkt_count,
  output logic [31:0]                 err_count,
  output logic [31:0]                 gap_count,
  output logic [63:0]                 last_counter_id,
  output logic [31:0]                 last_peak_index,
  output logic [63:0]                 last_peak_val,
  output logic [31:0]                 last_num_peaks,
  output logic                        report_valid
);

  generate
    if (S_AXI_DATA_WIDTH != 32'd512) begin : g_bad_s_width
      $error("peak_report_receiver: S_AXI_DATA_WIDTH must be 512");
    end
    if (M_AXI_DATA_WIDTH != 32'd64) begin : g_bad_m_width
      $error("peak_report_receiver: M_AXI_DATA_WIDTH must be 64");
    end
  endgenerate

  pk_state_e   state_r, state_s;
  logic        s_tready_r, m_tvalid_r, m_tlast_r, report_valid_r;
  logic [63:0] m_tdata_r, word_s;
  logic [63:0] cid_r, pval_r, last_cid_r, last_pval_r;
  logic [31:0] pidx_r, npk_r, cmax_r, last_pidx_r, last_npk_r;
  logic [7:0]  thr_r;
  logic        good_r, gap_r, seen_r;
  logic        accept_s, valid_in_s, gap_in_s, in_check_s;
  logic        unused_fields_s;

  assign accept_s = s_axis_tvalid & s_tready_r;

  // The auxiliary chirp fields are carried on the stream but not consumed here.
  assign unused_fields_s = ^s_axis_tdata[PK_CMAX_LSB-1:PK_AWG_LSB];

  // beat validation and continuity test against the previously latched id
  always_comb begin
    valid_in_s = (s_axis_tdata[PK_MAGIC_LSB +: 32] == PK_MAGIC)
               & (s_axis_tdata[PK_TAG_LSB +: 16] == PK_TAG)
               & (s_axis_tdata[PK_THR_LSB +: 8] == s_axis_tdata[PK_THR_DUP_LSB +: 8])
               & (s_axis_tdata[PK_PIDX_LSB +: 32] == s_axis_tdata[PK_PIDX_DUP_LSB +: 32])
               & (s_axis_tdata[PK_PVAL_LSB +: 64] == s_axis_tdata[PK_PVAL_DUP_LSB +: 64])
               & (s_axis_tdata[PK_NPK_LSB +: 32] == s_axis_tdata[PK_NPK_DUP_LSB +: 32])
               & s_axis_tlast;
    gap_in_s   = CHECK_SEQUENCE & valid_in_s & seen_r
               & (s_axis_tdata[PK_CID_LSB +: 64] != (last_cid_r + 64'd1));
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_s = ST_CHECK; else state_s = ST_IDLE;
      ST_CHECK: if (!good_r && DROP_ON_ERROR) state_s = ST_IDLE; else state_s = ST_W0;
      ST_W0:    if (m_axis_tready) state_s = ST_W1; else state_s = ST_W0;
      ST_W1:    if (m_axis_tready) state_s = ST_W2; else state_s = ST_W1;
      ST_W2:    if (m_axis_tready) state_s = ST_W3; else state_s = ST_W2;
      ST_W3:    if (m_axis_tready) state_s = ST_IDLE; else state_s = ST_W3;
      default:  state_s = ST_IDLE;
    endcase
  end

  // output word for the state about to be entered, so tdata holds while stalled
  always_comb begin
    word_s = 64'd0;
    case (state_s)
      ST_W0:   word_s = cid_r;
      ST_W1:   word_s = {pidx_r, npk_r};
      ST_W2:   word_s = pval_r;
      ST_W3:   word_s = {~good_r, 7'b0, thr_r, 16'b0, cmax_r};
      default: word_s = 64'd0;
    endcase
  end

  // state and registered stream handshake outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= ST_IDLE;
      s_tready_r <= 1'b0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tdata_r  <= 64'd0;
    end else begin
      state_r    <= state_s;
      s_tready_r <= (state_s == ST_IDLE);
      m_tvalid_r <= (state_s == ST_W0) | (state_s == ST_W1) | (state_s == ST_W2) | (state_s == ST_W3);
      m_tlast_r  <= (state_s == ST_W3);
      m_tdata_r  <= word_s;
    end
  end

  // Report capture; validity and gap are resolved at capture so the last_* fields and
  // report_valid become visible together during the CHECK cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cid_r  <= 64'd0;
      pidx_r <= 32'd0;
      pval_r <= 64'd0;
      npk_r  <= 32'd0;
      thr_r  <= 8'd0;
      cmax_r <= 32'd0;
      good_r <= 1'b0;
      gap_r  <= 1'b0;
    end else if (accept_s) begin
      cid_r  <= s_axis_tdata[PK_CID_LSB +: 64];
      pidx_r <= s_axis_tdata[PK_PIDX_LSB +: 32];
      pval_r <= s_axis_tdata[PK_PVAL_LSB +: 64];
      npk_r  <= s_axis_tdata[PK_NPK_LSB +: 32];
      thr_r  <= s_axis_tdata[PK_THR_LSB +: 8];
      cmax_r <= s_axis_tdata[PK_CMAX_LSB +: 32];
      good_r <= valid_in_s;
      gap_r  <= gap_in_s;
    end
  end

  // last-good-report latches, update pulse and first-report tracking
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_cid_r     <= 64'd0;
      last_pidx_r    <= 32'd0;
      last_pval_r    <= 64'd0;
      last_npk_r     <= 32'd0;
      report_valid_r <= 1'b0;
      seen_r         <= 1'b0;
    end else begin
      report_valid_r <= accept_s & valid_in_s;
      if (accept_s && valid_in_s) begin
        last_cid_r  <= s_axis_tdata[PK_CID_LSB +: 64];
        last_pidx_r <= s_axis_tdata[PK_PIDX_LSB +: 32];
        last_pval_r <= s_axis_tdata[PK_PVAL_LSB +: 64];
        last_npk_r  <= s_axis_tdata[PK_NPK_LSB +: 32];
      end
      if (clear_counters) begin
        seen_r <= 1'b0;
      end else if (accept_s && valid_in_s) begin
        seen_r <= 1'b1;
      end
    end
  end

  assign in_check_s = (state_r == ST_CHECK);

  sat_counter32 u_pkt_cnt (
    .aclk(aclk), .aresetn(aresetn), .inc(in_check_s & good_r), .clr(clear_counters), .q(pkt_count)
  );
  sat_counter32 u_err_cnt (
    .aclk(aclk), .aresetn(aresetn), .inc(in_check_s & ~good_r), .clr(clear_counters), .q(err_count)
  );
  sat_counter32 u_gap_cnt (
    .aclk(aclk), .aresetn(aresetn), .inc(in_check_s & gap_r), .clr(clear_counters), .q(gap_count)
  );

  assign s_axis_tready   = s_tready_r;
  assign m_axis_tdata    = m_tdata_r;
  assign m_axis_tvalid   = m_tvalid_r;
  assign m_axis_tlast    = m_tlast_r;
  assign last_counter_id = last_cid_r;
  assign last_peak_index = last_pidx_r;
  assign last_peak_val   = last_pval_r;
  assign last_num_peaks  = last_npk_r;
  assign report_valid    = report_valid_r;

endmodule
